// File: rtl/bram_arbiter.sv
// -----------------------------------------------------------------------------
// bram_arbiter
// Shares one single-port BRAM between two requesters (A and B) and can
// zero-fill the memory on request.
//
// Handshake: a requester raises i_x_req with its command fields held stable.
// o_x_gnt is a combinational reply in the same cycle. The access happens in
// any cycle where req and gnt are both high. A granted read returns its data
// one cycle later, marked by o_x_rvalid.
//
// Ports
//   i_clk, i_rst               clock, asynchronous active-high reset
//   i_clear                    start pulse for the zero-fill sequence
//   o_clearing, o_clear_done   zero-fill in progress / one-cycle completion pulse
//   i_a_* / i_b_*              request, write select, address, write data
//   o_a_gnt / o_b_gnt          combinational grants
//   o_a_rvalid / o_b_rvalid    registered read-data-valid strobes
//   o_a_rdata / o_b_rdata      read data (the BRAM output, passed through)
//   o_mem_addr/write/data      BRAM command port (combinational)
//   i_mem_data                 BRAM registered read output
// -----------------------------------------------------------------------------
module bram_arbiter #(
   parameter int ADDR_WIDTH = 13,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 8192
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_clear,
   output logic                  o_clearing,
   output logic                  o_clear_done,
   input  logic                  i_a_req,
   input  logic                  i_a_write,
   input  logic [ADDR_WIDTH-1:0] i_a_addr,
   input  logic [DATA_WIDTH-1:0] i_a_data,
   input  logic                  i_b_req,
   input  logic                  i_b_write,
   input  logic [ADDR_WIDTH-1:0] i_b_addr,
   input  logic [DATA_WIDTH-1:0] i_b_data,
   output logic                  o_a_gnt,
   output logic                  o_b_gnt,
   output logic                  o_a_rvalid,
   output logic                  o_b_rvalid,
   output logic [DATA_WIDTH-1:0] o_a_rdata,
   output logic [DATA_WIDTH-1:0] o_b_rdata,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   output logic                  o_mem_write,
   output logic [DATA_WIDTH-1:0] o_mem_data,
   input  logic [DATA_WIDTH-1:0] i_mem_data
);

   typedef enum logic {S_SERVE = 1'b0, S_CLEAR = 1'b1} state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   state_t                  r_state;
   state_t                  w_next_state;
   logic [ADDR_WIDTH-1:0]   r_cnt;
   logic                    r_last_b;      // 1: B was granted most recently
   logic                    r_a_rvalid;
   logic                    r_b_rvalid;
   logic                    r_clear_done;
   logic                    w_serve;
   logic                    w_clear_last;

   // Grants are only possible in SERVE, with no clear request and no reset.
   assign w_serve      = (r_state == S_SERVE) && !i_clear && !i_rst;
   assign w_clear_last = (r_state == S_CLEAR) && (r_cnt == LAST_ADDR);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= S_SERVE;
      else       r_state <= w_next_state;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_SERVE: if (i_clear)      w_next_state = S_CLEAR;
         S_CLEAR: if (w_clear_last) w_next_state = S_SERVE;
         default:                   w_next_state = S_SERVE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   // On contention the requester that was not granted last wins.
   always_comb begin
      o_a_gnt     = 1'b0;
      o_b_gnt     = 1'b0;
      o_mem_write = 1'b0;
      o_mem_addr  = '0;
      o_mem_data  = '0;
      o_clearing  = (r_state == S_CLEAR);
      if (w_serve) begin
         o_a_gnt = i_a_req && (!i_b_req ||  r_last_b);
         o_b_gnt = i_b_req && (!i_a_req || !r_last_b);
      end
      if (r_state == S_CLEAR && !i_rst) begin
         o_mem_write = 1'b1;
         o_mem_addr  = r_cnt;
      end else if (o_a_gnt) begin
         o_mem_write = i_a_write;
         o_mem_addr  = i_a_addr;
         o_mem_data  = i_a_data;
      end else if (o_b_gnt) begin
         o_mem_write = i_b_write;
         o_mem_addr  = i_b_addr;
         o_mem_data  = i_b_data;
      end
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt        <= '0;
         r_last_b     <= 1'b1;   // A wins the first contention after reset
         r_a_rvalid   <= 1'b0;
         r_b_rvalid   <= 1'b0;
         r_clear_done <= 1'b0;
      end else begin
         // Counter rests at 0 outside CLEAR so every clear starts at address 0.
         if (r_state == S_CLEAR)
            r_cnt <= w_clear_last ? '0 : r_cnt + 1'b1;
         else
            r_cnt <= '0;
         if (o_a_gnt)      r_last_b <= 1'b0;
         else if (o_b_gnt) r_last_b <= 1'b1;
         r_a_rvalid   <= o_a_gnt && !i_a_write;
         r_b_rvalid   <= o_b_gnt && !i_b_write;
         r_clear_done <= w_clear_last;
      end
   end

   assign o_a_rvalid   = r_a_rvalid;
   assign o_b_rvalid   = r_b_rvalid;
   assign o_clear_done = r_clear_done;
   assign o_a_rdata    = i_mem_data;
   assign o_b_rdata    = i_mem_data;

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter with a small behavioural BRAM model.
module tb_bram_arbiter;
   localparam int AW    = 8;
   localparam int DW    = 32;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          i_rst, i_clear;
   logic          i_a_req, i_a_write, i_b_req, i_b_write;
   logic [AW-1:0] i_a_addr, i_b_addr;
   logic [DW-1:0] i_a_data, i_b_data;
   logic          o_clearing, o_clear_done, o_a_gnt, o_b_gnt;
   logic          o_a_rvalid, o_b_rvalid, o_mem_write;
   logic [DW-1:0] o_a_rdata, o_b_rdata, o_mem_data;
   logic [AW-1:0] o_mem_addr;
   logic [DW-1:0] mem_q;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   bram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .i_clk(clk), .i_rst(i_rst), .i_clear(i_clear),
      .o_clearing(o_clearing), .o_clear_done(o_clear_done),
      .i_a_req(i_a_req), .i_a_write(i_a_write), .i_a_addr(i_a_addr), .i_a_data(i_a_data),
      .i_b_req(i_b_req), .i_b_write(i_b_write), .i_b_addr(i_b_addr), .i_b_data(i_b_data),
      .o_a_gnt(o_a_gnt), .o_b_gnt(o_b_gnt),
      .o_a_rvalid(o_a_rvalid), .o_b_rvalid(o_b_rvalid),
      .o_a_rdata(o_a_rdata), .o_b_rdata(o_b_rdata),
      .o_mem_addr(o_mem_addr), .o_mem_write(o_mem_write), .o_mem_data(o_mem_data),
      .i_mem_data(mem_q)
   );

   // BRAM model: unwritten words read as 0x1000 + address.
   logic [DW-1:0] mem     [0:(1<<AW)-1];
   logic          written [0:(1<<AW)-1] = '{default: 1'b0};
   always @(posedge clk) begin
      if (o_mem_write) begin
         mem[o_mem_addr]     <= o_mem_data;
         written[o_mem_addr] <= 1'b1;
      end else if ((o_a_gnt && !i_a_write) || (o_b_gnt && !i_b_write)) begin
         mem_q <= written[o_mem_addr] ? mem[o_mem_addr] : (32'h1000 + DW'(o_mem_addr));
      end
   end

   typedef struct {
      logic          rst, clr;
      logic          a_req, a_wr;
      logic [AW-1:0] a_addr;
      logic [DW-1:0] a_dat;
      logic          b_req, b_wr;
      logic [AW-1:0] b_addr;
      logic [DW-1:0] b_dat;
      logic          ea, eb, ew;
      logic [AW-1:0] eaddr;
      logic [DW-1:0] edata;
      logic          erva, ervb, chk_rd;
      logic [DW-1:0] erd;
   } vec_t;

   vec_t vq[$];

   task automatic add_in(input logic rst, clr, a_req, a_wr, input logic [AW-1:0] a_addr,
                         input logic [DW-1:0] a_dat, input logic b_req, b_wr,
                         input logic [AW-1:0] b_addr, input logic [DW-1:0] b_dat);
      vec_t v;
      v.rst = rst; v.clr = clr;
      v.a_req = a_req; v.a_wr = a_wr; v.a_addr = a_addr; v.a_dat = a_dat;
      v.b_req = b_req; v.b_wr = b_wr; v.b_addr = b_addr; v.b_dat = b_dat;
      v.ea = 0; v.eb = 0; v.ew = 0; v.eaddr = '0; v.edata = '0;
      v.erva = 0; v.ervb = 0; v.chk_rd = 0; v.erd = '0;
      vq.push_back(v);
   endtask

   task automatic add_exp(input logic ea, eb, ew, input logic [AW-1:0] eaddr,
                          input logic [DW-1:0] edata, input logic erva, ervb, chk_rd,
                          input logic [DW-1:0] erd);
      vec_t v;
      v = vq.pop_back();
      v.ea = ea; v.eb = eb; v.ew = ew; v.eaddr = eaddr; v.edata = edata;
      v.erva = erva; v.ervb = ervb; v.chk_rd = chk_rd; v.erd = erd;
      vq.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string nm, input logic ea, eb, ew, input logic [AW-1:0] eaddr,
                          input logic [DW-1:0] edata, input logic eclr, edone);
      chk({nm, " a_gnt"},      DW'(o_a_gnt),      DW'(ea));
      chk({nm, " b_gnt"},      DW'(o_b_gnt),      DW'(eb));
      chk({nm, " mem_write"},  DW'(o_mem_write),  DW'(ew));
      chk({nm, " mem_addr"},   DW'(o_mem_addr),   DW'(eaddr));
      chk({nm, " mem_data"},   o_mem_data,        edata);
      chk({nm, " clearing"},   DW'(o_clearing),   DW'(eclr));
      chk({nm, " clear_done"}, DW'(o_clear_done), DW'(edone));
   endtask

   task automatic idle_inputs();
      i_clear = 0; i_a_req = 0; i_a_write = 0; i_a_addr = '0; i_a_data = '0;
      i_b_req = 0; i_b_write = 0; i_b_addr = '0; i_b_data = '0;
   endtask

   initial begin
      i_rst = 1'b1;
      idle_inputs();

      //     rst clr aR aW aAddr  aData         bR bW bAddr  bData
      add_in(1, 0, 1, 0, 8'd0,  32'h0,        1, 0, 8'd0,  32'h0);
      add_exp(0, 0, 0, 8'd0, 32'h0, 0, 0, 0, 32'h0);
      add_in(0, 0, 1, 1, 8'd5,  32'hDEADBEEF, 0, 0, 8'd0,  32'h0);
      add_exp(1, 0, 1, 8'd5, 32'hDEADBEEF, 0, 0, 0, 32'h0);
      add_in(0, 0, 1, 0, 8'd5,  32'h0,        0, 0, 8'd0,  32'h0);
      add_exp(1, 0, 0, 8'd5, 32'h0, 0, 0, 0, 32'h0);
      add_in(0, 0, 0, 1, 8'h33, 32'h1234,     0, 1, 8'h44, 32'h5678);
      add_exp(0, 0, 0, 8'd0, 32'h0, 1, 0, 1, 32'hDEADBEEF);
      add_in(1, 0, 0, 0, 8'd0,  32'h0,        0, 0, 8'd0,  32'h0);
      add_exp(0, 0, 0, 8'd0, 32'h0, 0, 0, 0, 32'h0);
      // both read for 4 cycles after reset: A, B, A, B
      add_in(0, 0, 1, 0, 8'd1,  32'h0,        1, 0, 8'd2,  32'h0);
      add_exp(1, 0, 0, 8'd1, 32'h0, 0, 0, 0, 32'h0);
      add_in(0, 0, 1, 0, 8'd1,  32'h0,        1, 0, 8'd2,  32'h0);
      add_exp(0, 1, 0, 8'd2, 32'h0, 1, 0, 1, 32'h1001);
      add_in(0, 0, 1, 0, 8'd1,  32'h0,        1, 0, 8'd2,  32'h0);
      add_exp(1, 0, 0, 8'd1, 32'h0, 0, 1, 1, 32'h1002);
      add_in(0, 0, 1, 0, 8'd1,  32'h0,        1, 0, 8'd2,  32'h0);
      add_exp(0, 1, 0, 8'd2, 32'h0, 1, 0, 1, 32'h1001);
      add_in(0, 0, 0, 0, 8'd0,  32'h0,        0, 0, 8'd0,  32'h0);
      add_exp(0, 0, 0, 8'd0, 32'h0, 0, 1, 1, 32'h1002);
      // writes give no rvalid
      add_in(0, 0, 0, 0, 8'd0,  32'h0,        1, 1, 8'd3,  32'h55);
      add_exp(0, 1, 1, 8'd3, 32'h55, 0, 0, 0, 32'h0);
      add_in(0, 0, 1, 1, 8'd7,  32'h77,       0, 0, 8'd0,  32'h0);
      add_exp(1, 0, 1, 8'd7, 32'h77, 0, 0, 0, 32'h0);
      // reset, B alone, then contention: A wins
      add_in(1, 0, 0, 0, 8'd0,  32'h0,        0, 0, 8'd0,  32'h0);
      add_exp(0, 0, 0, 8'd0, 32'h0, 0, 0, 0, 32'h0);
      add_in(0, 0, 0, 0, 8'd0,  32'h0,        1, 0, 8'd3,  32'h0);
      add_exp(0, 1, 0, 8'd3, 32'h0, 0, 0, 0, 32'h0);
      add_in(0, 0, 1, 0, 8'd4,  32'h0,        1, 0, 8'd3,  32'h0);
      add_exp(1, 0, 0, 8'd4, 32'h0, 0, 1, 1, 32'h55);
      add_in(0, 0, 0, 0, 8'd0,  32'h0,        0, 0, 8'd0,  32'h0);
      add_exp(0, 0, 0, 8'd0, 32'h0, 1, 0, 1, 32'h1004);

      repeat (2) @(negedge clk);
      foreach (vq[i]) begin
         @(negedge clk);
         i_rst = vq[i].rst; i_clear = vq[i].clr;
         i_a_req = vq[i].a_req; i_a_write = vq[i].a_wr; i_a_addr = vq[i].a_addr; i_a_data = vq[i].a_dat;
         i_b_req = vq[i].b_req; i_b_write = vq[i].b_wr; i_b_addr = vq[i].b_addr; i_b_data = vq[i].b_dat;
         #2;
         chk_all($sformatf("v%0d", i), vq[i].ea, vq[i].eb, vq[i].ew, vq[i].eaddr, vq[i].edata, 1'b0, 1'b0);
         chk($sformatf("v%0d a_rvalid", i), DW'(o_a_rvalid), DW'(vq[i].erva));
         chk($sformatf("v%0d b_rvalid", i), DW'(o_b_rvalid), DW'(vq[i].ervb));
         if (vq[i].chk_rd)
            chk($sformatf("v%0d rdata", i), vq[i].erva ? o_a_rdata : o_b_rdata, vq[i].erd);
      end

      // Read granted just before clear still returns data; clear blocks A's grant.
      @(negedge clk);
      idle_inputs();
      i_a_req = 1; i_a_addr = 8'd9;
      #2 chk_all("pre_clr", 1, 0, 0, 8'd9, 32'h0, 0, 0);
      @(negedge clk);
      i_clear = 1;
      #2 chk_all("clr_req", 0, 0, 0, 8'd0, 32'h0, 0, 0);
      chk("clr_req a_rvalid", DW'(o_a_rvalid), 32'd1);
      chk("clr_req rdata", o_a_rdata, 32'h1009);
      i_a_addr = 8'd15;
      for (int k = 0; k < DEPTH; k++) begin
         @(negedge clk);
         i_clear = (k == 3);   // re-trigger during CLEAR must be ignored
         #2 chk_all($sformatf("clr%0d", k), 0, 0, 1, AW'(k), 32'h0, 1, 0);
      end
      @(negedge clk);
      i_clear = 0;
      #2 chk_all("clr_end", 1, 0, 0, 8'd15, 32'h0, 0, 1);
      @(negedge clk);
      i_a_req = 0;
      #2 chk_all("post_clr", 0, 0, 0, 8'd0, 32'h0, 0, 0);
      chk("post_clr a_rvalid", DW'(o_a_rvalid), 32'd1);
      chk("post_clr rdata", o_a_rdata, 32'h0);

      // Reset at clear cycle 7 aborts without a done pulse.
      @(negedge clk);
      i_clear = 1;
      @(negedge clk);
      i_clear = 0;
      for (int k = 0; k < 7; k++) begin
         if (k > 0) @(negedge clk);
         #2 chk_all($sformatf("abort%0d", k), 0, 0, 1, AW'(k), 32'h0, 1, 0);
      end
      @(negedge clk);
      i_rst = 1; i_b_req = 1; i_b_addr = 8'd4;
      #2 chk_all("abort_rst", 0, 0, 0, 8'd0, 32'h0, 0, 0);
      @(negedge clk);
      i_rst = 0;
      #2 chk_all("abort_b", 0, 1, 0, 8'd4, 32'h0, 0, 0);
      @(negedge clk);
      i_b_req = 0;
      #2 chk_all("abort_idle", 0, 0, 0, 8'd0, 32'h0, 0, 0);
      chk("abort b_rvalid", DW'(o_b_rvalid), 32'd1);
      chk("abort rdata", o_b_rdata, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
